// File: rtl/sdfm_regmap_pkg.sv
// Shared address map, bit positions and helpers for the sigma-delta filter register map.
// Every register is 32 bits wide and word aligned.
package sdfm_regmap_pkg;

  localparam logic [7:0] ADDR_CTL        = 8'h00;
  localparam logic [7:0] ADDR_STAT       = 8'h04;
  localparam logic [7:0] ADDR_IEN        = 8'h08;
  localparam logic [7:0] ADDR_FPARM_BASE = 8'h10;
  localparam logic [7:0] ADDR_FDATA_BASE = 8'h30;

  localparam int CTL_RSTEN    = 0;
  localparam int CTL_CLKEN    = 1;
  localparam int STAT_OVR_LSB = 16;

  function automatic logic [7:0] fparm_addr(input int unsigned ch);
    return ADDR_FPARM_BASE + 8'(ch * 4);
  endfunction

  function automatic logic [7:0] fdata_addr(input int unsigned ch);
    return ADDR_FDATA_BASE + 8'(ch * 4);
  endfunction

  // Bits of STAT/IEN that actually exist for a map with n channels.
  function automatic logic [31:0] flag_mask(input int unsigned n);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < n; i++) begin
      m[i]                = 1'b1;
      m[STAT_OVR_LSB + i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sdfm_ch_status.sv
// One filter channel's capture register with its sticky data-ready and overrun flags.
// A new capture always wins over any clear arriving in the same cycle.
module sdfm_ch_status
  import sdfm_regmap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic [31:0] fifo_data,
  input  logic        rd_clr,
  input  logic        w1c_drdy,
  input  logic        w1c_ovr,
  output logic [31:0] fdata,
  output logic        drdy,
  output logic        ovr
);

  logic drdy_clr;

  assign drdy_clr = rd_clr | w1c_drdy;

  // Overrun means unread data is being overwritten; a read in the same cycle consumes it first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fdata <= '0;
      drdy  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (data_valid) begin
        fdata <= fifo_data;
      end
      drdy <= data_valid | (drdy & ~drdy_clr);
      ovr  <= (data_valid & drdy & ~drdy_clr) | (ovr & ~w1c_ovr);
    end
  end

endmodule

// File: rtl/sdfm_regmap.sv
// Bus-facing register map for the sigma-delta filter: control, per-channel parameters,
// captured results, write-1-to-clear status and a registered interrupt line.
module sdfm_regmap
  import sdfm_regmap_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter int          DW        = 32,
  parameter logic [31:0] FPARM_RST = 32'h0000_0000
) (
  input  logic              EXTCLK,
  input  logic              EXTRSTn,
  input  logic              WR,
  input  logic              RD,
  input  logic [7:0]        ADDR,
  input  logic [DW-1:0]     WDATA,
  output logic [DW-1:0]     RDATA,
  output logic              reg_rsten,
  output logic              reg_clken,
  output logic [NCH*32-1:0] reg_fparm,
  input  logic [NCH*32-1:0] fifo_data,
  input  logic [NCH-1:0]    data_valid,
  output logic              irq
);

  localparam logic [31:0] IEN_MASK = flag_mask(NCH);

  logic [1:0]              ctl;
  logic [31:0]             ien;
  logic [NCH-1:0][31:0]    fparm;
  logic [NCH-1:0][31:0]    fdata;
  logic [NCH-1:0]          drdy;
  logic [NCH-1:0]          ovr;
  logic [31:0]             stat;
  logic                    hit_ctl;
  logic                    hit_stat;
  logic                    hit_ien;
  logic [NCH-1:0]          hit_fparm;
  logic [NCH-1:0]          hit_fdata;
  logic                    wr_stat;
  logic [31:0]             rd_mux;

  // Exact-match decode against aligned constants, so misaligned or unmapped addresses hit nothing.
  always_comb begin
    hit_ctl   = (ADDR == ADDR_CTL);
    hit_stat  = (ADDR == ADDR_STAT);
    hit_ien   = (ADDR == ADDR_IEN);
    hit_fparm = '0;
    hit_fdata = '0;
    for (int i = 0; i < NCH; i++) begin
      hit_fparm[i] = (ADDR == fparm_addr(i));
      hit_fdata[i] = (ADDR == fdata_addr(i));
    end
  end

  assign wr_stat = WR & hit_stat;

  always_comb begin
    stat = '0;
    stat[NCH-1:0]              = drdy;
    stat[STAT_OVR_LSB +: NCH]  = ovr;
  end

  always_comb begin
    rd_mux = '0;
    if (hit_ctl) begin
      rd_mux[1:0] = ctl;
    end
    if (hit_stat) begin
      rd_mux = stat;
    end
    if (hit_ien) begin
      rd_mux = ien;
    end
    for (int i = 0; i < NCH; i++) begin
      if (hit_fparm[i]) begin
        rd_mux = fparm[i];
      end
      if (hit_fdata[i]) begin
        rd_mux = fdata[i];
      end
    end
  end

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      ctl   <= '0;
      ien   <= '0;
      fparm <= {NCH{FPARM_RST}};
    end else if (WR) begin
      if (hit_ctl) begin
        ctl <= WDATA[CTL_CLKEN:CTL_RSTEN];
      end
      if (hit_ien) begin
        ien <= WDATA & IEN_MASK;
      end
      for (int i = 0; i < NCH; i++) begin
        if (hit_fparm[i]) begin
          fparm[i] <= WDATA;
        end
      end
    end
  end

  // Read data is captured from pre-edge state, so a same-cycle write is not yet visible.
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      RDATA <= '0;
    end else if (RD) begin
      RDATA <= rd_mux;
    end
  end

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      irq <= 1'b0;
    end else begin
      irq <= |(stat & ien);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sdfm_ch_status u_ch (
      .clk        (EXTCLK),
      .rst_n      (EXTRSTn),
      .data_valid (data_valid[g]),
      .fifo_data  (fifo_data[32*g +: 32]),
      .rd_clr     (RD & hit_fdata[g]),
      .w1c_drdy   (wr_stat & WDATA[g]),
      .w1c_ovr    (wr_stat & WDATA[STAT_OVR_LSB + g]),
      .fdata      (fdata[g]),
      .drdy       (drdy[g]),
      .ovr        (ovr[g])
    );
  end

  assign reg_rsten = ctl[CTL_RSTEN];
  assign reg_clken = ctl[CTL_CLKEN];
  assign reg_fparm = fparm;

endmodule

// File: tb/tb_sdfm_regmap.sv
// Directed and randomized checks of sdfm_regmap against a behavioural register-map model.
module tb_sdfm_regmap;

  localparam int          NCH       = 4;
  localparam logic [31:0] FPARM_RST = 32'hC0DE_0F0F;

  logic              EXTCLK;
  logic              EXTRSTn;
  logic              WR;
  logic              RD;
  logic [7:0]        ADDR;
  logic [31:0]       WDATA;
  logic [31:0]       RDATA;
  logic              reg_rsten;
  logic              reg_clken;
  logic [NCH*32-1:0] reg_fparm;
  logic [NCH*32-1:0] fifo_data;
  logic [NCH-1:0]    data_valid;
  logic              irq;

  int tests = 0;
  int fails = 0;

  logic [1:0]  m_ctl;
  logic [31:0] m_ien;
  logic [31:0] m_fparm [NCH];
  logic [31:0] m_fdata [NCH];
  logic [NCH-1:0] m_drdy;
  logic [NCH-1:0] m_ovr;
  logic [31:0] m_rdata;
  logic        m_irq;

  sdfm_regmap #(.NCH(NCH), .DW(32), .FPARM_RST(FPARM_RST)) dut (
    .EXTCLK     (EXTCLK),
    .EXTRSTn    (EXTRSTn),
    .WR         (WR),
    .RD         (RD),
    .ADDR       (ADDR),
    .WDATA      (WDATA),
    .RDATA      (RDATA),
    .reg_rsten  (reg_rsten),
    .reg_clken  (reg_clken),
    .reg_fparm  (reg_fparm),
    .fifo_data  (fifo_data),
    .data_valid (data_valid),
    .irq        (irq)
  );

  initial EXTCLK = 1'b0;
  always #5 EXTCLK = ~EXTCLK;

  function automatic logic [31:0] modelStat();
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < NCH; i++) begin
      s[i]      = m_drdy[i];
      s[16 + i] = m_ovr[i];
    end
    return s;
  endfunction

  function automatic int fparmIndex(input logic [7:0] a);
    if (a[1:0] == 2'b00 && a >= 8'h10 && int'(a) < 16 + 4 * NCH) return (int'(a) - 16) / 4;
    return -1;
  endfunction

  function automatic int fdataIndex(input logic [7:0] a);
    if (a[1:0] == 2'b00 && a >= 8'h30 && int'(a) < 48 + 4 * NCH) return (int'(a) - 48) / 4;
    return -1;
  endfunction

  function automatic logic [31:0] modelRead(input logic [7:0] a);
    if (a == 8'h00) return {30'b0, m_ctl};
    if (a == 8'h04) return modelStat();
    if (a == 8'h08) return m_ien;
    if (fparmIndex(a) >= 0) return m_fparm[fparmIndex(a)];
    if (fdataIndex(a) >= 0) return m_fdata[fdataIndex(a)];
    return 32'h0;
  endfunction

  function automatic logic [NCH*32-1:0] chData(input int ch, input logic [31:0] v);
    logic [NCH*32-1:0] f;
    f = '0;
    f[32*ch +: 32] = v;
    return f;
  endfunction

  task automatic modelReset();
    m_ctl   = '0;
    m_ien   = '0;
    m_drdy  = '0;
    m_ovr   = '0;
    m_rdata = '0;
    m_irq   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_fparm[i] = FPARM_RST;
      m_fdata[i] = '0;
    end
  endtask

  // One bus cycle of the reference model, evaluated from pre-edge state.
  task automatic modelStep(input logic wr, input logic rd, input logic [7:0] a,
                           input logic [31:0] wd, input logic [NCH-1:0] dv,
                           input logic [NCH*32-1:0] fd);
    logic [NCH-1:0] clr_d;
    logic [NCH-1:0] clr_o;
    if (rd) m_rdata = modelRead(a);
    m_irq = |(modelStat() & m_ien);
    for (int i = 0; i < NCH; i++) begin
      clr_d[i] = (rd && fdataIndex(a) == i) || (wr && a == 8'h04 && wd[i]);
      clr_o[i] = wr && a == 8'h04 && wd[16 + i];
    end
    m_ovr  = (dv & m_drdy & ~clr_d) | (m_ovr & ~clr_o);
    m_drdy = dv | (m_drdy & ~clr_d);
    for (int i = 0; i < NCH; i++) begin
      if (dv[i]) m_fdata[i] = fd[32*i +: 32];
    end
    if (wr) begin
      if (a == 8'h00) m_ctl = wd[1:0];
      if (a == 8'h08) m_ien = wd & 32'h000F_000F;
      if (fparmIndex(a) >= 0) m_fparm[fparmIndex(a)] = wd;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("rdata", RDATA, m_rdata);
    checkOutput("rsten", {31'b0, reg_rsten}, {31'b0, m_ctl[0]});
    checkOutput("clken", {31'b0, reg_clken}, {31'b0, m_ctl[1]});
    checkOutput("irq", {31'b0, irq}, {31'b0, m_irq});
    for (int i = 0; i < NCH; i++) checkOutput("fparm_out", reg_fparm[32*i +: 32], m_fparm[i]);
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] a,
                               input logic [31:0] wd, input logic [NCH-1:0] dv,
                               input logic [NCH*32-1:0] fd);
    WR = wr; RD = rd; ADDR = a; WDATA = wd; data_valid = dv; fifo_data = fd;
    modelStep(wr, rd, a, wd, dv, fd);
    @(posedge EXTCLK);
    #1;
    WR = 1'b0; RD = 1'b0; data_valid = '0;
    checkAll();
  endtask

  task automatic busWrite(input logic [7:0] a, input logic [31:0] wd);
    applyStimulus(1'b1, 1'b0, a, wd, '0, '0);
  endtask

  task automatic busRead(input logic [7:0] a);
    applyStimulus(1'b0, 1'b1, a, '0, '0, '0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 8'h00, '0, '0, '0);
  endtask

  logic [7:0] addr_list [17] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                                 8'h20, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h02, 8'h70, 8'hFF};
  logic [7:0] mapped [11] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C,
                              8'h30, 8'h34, 8'h38, 8'h3C};

  initial begin
    EXTRSTn = 1'b0; WR = 1'b0; RD = 1'b0; ADDR = '0; WDATA = '0;
    data_valid = '0; fifo_data = '0;
    modelReset();
    repeat (3) @(posedge EXTCLK);
    #1;
    EXTRSTn = 1'b1;
    checkAll();

    // Reset values of every mapped register.
    for (int k = 0; k < 11; k++) begin
      busRead(mapped[k]);
      checkOutput("reset_read", RDATA, (mapped[k] >= 8'h10 && mapped[k] < 8'h20) ? FPARM_RST : 32'h0);
    end

    busWrite(8'h00, 32'hFFFF_FFFF);
    checkOutput("ctl_rsten", {31'b0, reg_rsten}, 32'h1);
    checkOutput("ctl_clken", {31'b0, reg_clken}, 32'h1);
    busRead(8'h00);
    checkOutput("ctl_read", RDATA, 32'h0000_0003);

    busWrite(8'h18, 32'hA5A5_1234);
    checkOutput("fparm2_direct", reg_fparm[95:64], 32'hA5A5_1234);
    busRead(8'h18);
    checkOutput("fparm2_read", RDATA, 32'hA5A5_1234);

    // Interrupt from channel 1 data-ready.
    busWrite(8'h08, 32'h0000_0002);
    applyStimulus(1'b0, 1'b0, 8'h00, '0, 4'b0010, chData(1, 32'h0000_BEEF));
    checkOutput("irq_not_yet", {31'b0, irq}, 32'h0);
    busRead(8'h04);
    checkOutput("stat_drdy1", RDATA, 32'h0000_0002);
    checkOutput("irq_set", {31'b0, irq}, 32'h1);
    busRead(8'h34);
    checkOutput("fdata1_read", RDATA, 32'h0000_BEEF);
    idle();
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);

    // Overrun on channel 0.
    busWrite(8'h04, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 8'h00, '0, 4'b0001, chData(0, 32'h11));
    applyStimulus(1'b0, 1'b0, 8'h00, '0, 4'b0001, chData(0, 32'h22));
    busRead(8'h04);
    checkOutput("stat_ovr0", RDATA, 32'h0001_0001);
    busWrite(8'h04, 32'h0001_0000);
    busRead(8'h04);
    checkOutput("stat_ovr0_clr", RDATA, 32'h0000_0001);
    busRead(8'h30);
    checkOutput("fdata0_last", RDATA, 32'h22);

    // Read racing a capture on channel 3.
    busWrite(8'h04, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 8'h00, '0, 4'b1000, chData(3, 32'h5));
    applyStimulus(1'b0, 1'b1, 8'h3C, '0, 4'b1000, chData(3, 32'h6));
    checkOutput("fdata3_old", RDATA, 32'h5);
    busRead(8'h04);
    checkOutput("stat_ch3_race", RDATA & 32'h0008_0008, 32'h0000_0008);
    busRead(8'h3C);
    checkOutput("fdata3_new", RDATA, 32'h6);

    // Simultaneous write and read of one register returns the old value.
    applyStimulus(1'b1, 1'b1, 8'h10, 32'h1357_9BDF, '0, '0);
    checkOutput("wr_rd_old", RDATA, FPARM_RST);
    checkOutput("wr_rd_new", reg_fparm[31:0], 32'h1357_9BDF);

    // Ignored writes and unmapped reads.
    busWrite(8'h30, 32'hDEAD_DEAD);
    busWrite(8'h02, 32'hDEAD_DEAD);
    busWrite(8'h70, 32'hDEAD_DEAD);
    busRead(8'h30);
    checkOutput("fdata0_ro", RDATA, 32'h22);
    busRead(8'h70);
    checkOutput("unmapped_70", RDATA, 32'h0);
    busRead(8'h20);
    checkOutput("fparm_oob", RDATA, 32'h0);
    busRead(8'h02);
    checkOutput("misaligned", RDATA, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] a;
      logic [NCH-1:0] dv;
      logic [NCH*32-1:0] fd;
      a  = addr_list[$urandom_range(16, 0)];
      dv = ($urandom_range(2, 0) == 0) ? NCH'($urandom) : '0;
      fd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'($urandom_range(2, 0) == 0), 1'($urandom_range(1, 0)), a,
                    ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : $urandom, dv, fd);
    end

    // Asynchronous reset in the middle of an access.
    busWrite(8'h08, 32'hFFFF_FFFF);
    busWrite(8'h00, 32'h3);
    applyStimulus(1'b0, 1'b1, 8'h04, '0, 4'b1111, {$urandom, $urandom, $urandom, $urandom});
    idle();
    WR = 1'b1; ADDR = 8'h14; WDATA = 32'h7777_7777;
    #2;
    EXTRSTn = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("async_rst_irq", {31'b0, irq}, 32'h0);
    @(posedge EXTCLK);
    #1;
    WR = 1'b0;
    #2;
    EXTRSTn = 1'b1;
    @(posedge EXTCLK);
    #1;
    checkAll();
    for (int k = 0; k < 11; k++) begin
      busRead(mapped[k]);
      checkOutput("post_reset_read", RDATA, (mapped[k] >= 8'h10 && mapped[k] < 8'h20) ? FPARM_RST : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
